// File: rtl/block_map_pkg.sv
// Shared block codes, field geometry and FSM state type for the playfield block map.
package block_map_pkg;

    localparam int FIELD_ROWS = 30;
    localparam int FIELD_COLS = 10;

    localparam logic [2:0] BLK_EMPTY       = 3'b000;
    localparam logic [2:0] BLK_SOLID       = 3'b111;
    localparam logic [2:0] BLK_TWO_HIT     = 3'b011;
    localparam logic [2:0] BLK_TWO_HIT_DMG = 3'b010;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    // A cell contributes to the remaining count when it is neither empty nor indestructible.
    function automatic logic is_counted(input logic [2:0] code);
        return (code != BLK_EMPTY) && (code != BLK_SOLID);
    endfunction

endpackage

// File: rtl/level_pattern.sv
// Combinational level layout generator: maps (level, row, col) to the block code
// that a freshly loaded level holds in that cell.
module level_pattern
    import block_map_pkg::*;
#(
    parameter int COLS = FIELD_COLS
) (
    input  logic [2:0] level,
    input  logic [4:0] row,
    input  logic [4:0] col,
    output logic [2:0] code
);

    logic [4:0] last_row;
    logic [4:0] band;

    // Filled band ends at row 9+level, capped at row 16.
    always_comb begin
        last_row = 5'd9 + {2'b00, level};
        if (last_row > 5'd16) begin
            last_row = 5'd16;
        end else begin
            last_row = last_row;
        end
    end

    // Code selection: solid corners on level 2+, two-hit rows on odd levels, else the striped wide bricks.
    always_comb begin
        band = (row - 5'd2) % 5'd3;
        code = BLK_EMPTY;
        if ((row >= 5'd2) && (row <= last_row)) begin
            if ((level >= 3'd2) && (row == 5'd2) && ((col == 5'd0) || (col == 5'(COLS - 1)))) begin
                code = BLK_SOLID;
            end else if (level[0] && ((row % 5'd3) == 5'd0)) begin
                code = BLK_TWO_HIT;
            end else begin
                code = {1'b1, band[1:0]};
            end
        end else begin
            code = BLK_EMPTY;
        end
    end

endmodule

// File: rtl/block_map.sv
// Playfield block storage: renderer read port, level loader and brick-hit service.
// Optional feature macro: BLOCK_MAP_TWO_HIT_EN (011 bricks take two hits).
module block_map
    import block_map_pkg::*;
#(
    parameter int ROWS   = FIELD_ROWS,
    parameter int COLS   = FIELD_COLS,
    parameter int LEVELS = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_req,
    input  logic [2:0] level,
    output logic       busy,
    input  logic [4:0] sel_row,
    input  logic [4:0] sel_col,
    output logic [2:0] block,
    input  logic       hit_req,
    input  logic [4:0] hit_row,
    input  logic [4:0] hit_col,
    output logic       hit_ack,
    output logic [2:0] hit_block,
    output logic       hit_destroyed,
    output logic [8:0] remaining,
    output logic       level_clear
);

    localparam int CELLS = ROWS * COLS;
    localparam int AW    = $clog2(CELLS);

    logic [2:0]    map [CELLS];
    state_t        state;
    logic [AW-1:0] load_addr;
    logic [4:0]    load_row;
    logic [4:0]    load_col;
    logic [2:0]    load_level;
    logic          loaded;
    logic [2:0]    pat_code;

    logic          hit_in_range;
    logic [AW-1:0] hit_idx;
    logic [2:0]    hit_code;
    logic [2:0]    hit_new;
    logic          hit_write;
    logic          hit_dec;

    level_pattern #(.COLS(COLS)) u_level_pattern (
        .level (load_level),
        .row   (load_row),
        .col   (load_col),
        .code  (pat_code)
    );

    // Renderer read port; out-of-field coordinates read as empty.
    always_comb begin
        if ((sel_row < 5'(ROWS)) && (sel_col < 5'(COLS))) begin
            block = map[AW'(sel_row * COLS + sel_col)];
        end else begin
            block = BLK_EMPTY;
        end
    end

    // Hit lookup and the code the cell takes after being struck.
    always_comb begin
        hit_in_range = (hit_row < 5'(ROWS)) && (hit_col < 5'(COLS));
        hit_idx      = AW'(hit_row * COLS + hit_col);
        if (hit_in_range) begin
            hit_code = map[hit_idx];
        end else begin
            hit_code = BLK_EMPTY;
        end
        hit_new   = BLK_EMPTY;
        hit_write = 1'b0;
        hit_dec   = 1'b0;
        if (is_counted(hit_code)) begin
`ifdef BLOCK_MAP_TWO_HIT_EN
            if (hit_code == BLK_TWO_HIT) begin
                hit_new   = BLK_TWO_HIT_DMG;
                hit_write = 1'b1;
                hit_dec   = 1'b0;
            end else begin
                hit_new   = BLK_EMPTY;
                hit_write = 1'b1;
                hit_dec   = 1'b1;
            end
`else
            hit_new   = BLK_EMPTY;
            hit_write = 1'b1;
            hit_dec   = 1'b1;
`endif
        end else begin
            hit_write = 1'b0;
            hit_dec   = 1'b0;
        end
    end

    // Main FSM: level load sweep, hit servicing and the remaining-brick counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < CELLS; i++) begin
                map[i] <= BLK_EMPTY;
            end
            state         <= IDLE;
            busy          <= 1'b0;
            hit_ack       <= 1'b0;
            hit_block     <= BLK_EMPTY;
            hit_destroyed <= 1'b0;
            remaining     <= 9'd0;
            loaded        <= 1'b0;
            load_addr     <= '0;
            load_row      <= 5'd0;
            load_col      <= 5'd0;
            load_level    <= 3'd0;
        end else begin
            hit_ack       <= 1'b0;
            hit_block     <= BLK_EMPTY;
            hit_destroyed <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_req) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        load_level <= (int'({29'd0, level}) < LEVELS) ? level : 3'(LEVELS - 1);
                        load_addr  <= '0;
                        load_row   <= 5'd0;
                        load_col   <= 5'd0;
                        remaining  <= 9'd0;
                        loaded     <= 1'b0;
                    end else if (hit_req) begin
                        hit_ack       <= 1'b1;
                        hit_block     <= hit_code;
                        hit_destroyed <= hit_dec;
                        if (hit_write) begin
                            map[hit_idx] <= hit_new;
                        end
                        if (hit_dec) begin
                            remaining <= remaining - 9'd1;
                        end
                    end
                end
                LOAD: begin
                    map[load_addr] <= pat_code;
                    if (is_counted(pat_code)) begin
                        remaining <= remaining + 9'd1;
                    end
                    if (load_addr == AW'(CELLS - 1)) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        loaded <= 1'b1;
                    end else begin
                        load_addr <= load_addr + AW'(1);
                        if (load_col == 5'(COLS - 1)) begin
                            load_col <= 5'd0;
                            load_row <= load_row + 5'd1;
                        end else begin
                            load_col <= load_col + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign level_clear = loaded && (remaining == 9'd0) && !busy;

endmodule

// File: tb/tb_block_map.sv
// Self-checking bench for block_map: cycle-level behavioural model plus directed literal checks.
module tb_block_map;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_req;
    logic [2:0] level;
    logic       busy;
    logic [4:0] sel_row;
    logic [4:0] sel_col;
    logic [2:0] block;
    logic       hit_req;
    logic [4:0] hit_row;
    logic [4:0] hit_col;
    logic       hit_ack;
    logic [2:0] hit_block;
    logic       hit_destroyed;
    logic [8:0] remaining;
    logic       level_clear;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    block_map dut (
        .clock         (clk),
        .reset         (reset),
        .load_req      (load_req),
        .level         (level),
        .busy          (busy),
        .sel_row       (sel_row),
        .sel_col       (sel_col),
        .block         (block),
        .hit_req       (hit_req),
        .hit_row       (hit_row),
        .hit_col       (hit_col),
        .hit_ack       (hit_ack),
        .hit_block     (hit_block),
        .hit_destroyed (hit_destroyed),
        .remaining     (remaining),
        .level_clear   (level_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0] m_map [300];
    bit         m_loading = 1'b0;
    bit         m_loaded  = 1'b0;
    int         m_pos     = 0;
    int         m_level   = 0;
    bit         e_ack     = 1'b0;
    bit         e_hd      = 1'b0;
    logic [2:0] e_hb      = 3'd0;

    function automatic logic [2:0] layout(input int lv, input int idx);
        int row;
        int col;
        int last;
        row  = idx / 10;
        col  = idx % 10;
        last = (9 + lv < 16) ? 9 + lv : 16;
        if (row < 2 || row > last) return 3'd0;
        if (lv >= 2 && row == 2 && (col == 0 || col == 9)) return 3'd7;
        if ((lv % 2) == 1 && (row % 3) == 0) return 3'd3;
        return 3'(4 + (row - 2) % 3);
    endfunction

    function automatic int count_live(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (m_map[i] != 3'd0 && m_map[i] != 3'd7) c++;
        end
        return c;
    endfunction

    task automatic model_step();
        int         idx;
        logic [2:0] code;
        if (reset) begin
            for (int i = 0; i < 300; i++) m_map[i] = 3'd0;
            m_loading = 1'b0;
            m_loaded  = 1'b0;
            m_pos     = 0;
            e_ack     = 1'b0;
            e_hb      = 3'd0;
            e_hd      = 1'b0;
        end else begin
            e_ack = 1'b0;
            e_hb  = 3'd0;
            e_hd  = 1'b0;
            if (m_loading) begin
                m_map[m_pos] = layout(m_level, m_pos);
                m_pos++;
                if (m_pos == 300) begin
                    m_loading = 1'b0;
                    m_loaded  = 1'b1;
                end
            end else if (load_req) begin
                m_loading = 1'b1;
                m_loaded  = 1'b0;
                m_pos     = 0;
                m_level   = int'(level);
            end else if (hit_req) begin
                e_ack = 1'b1;
                idx   = int'(hit_row) * 10 + int'(hit_col);
                code  = (hit_row < 5'd30 && hit_col < 5'd10) ? m_map[idx] : 3'd0;
                e_hb  = code;
                if (code != 3'd0 && code != 3'd7) begin
`ifdef BLOCK_MAP_TWO_HIT_EN
                    if (code == 3'd3) begin
                        m_map[idx] = 3'd2;
                    end else begin
                        m_map[idx] = 3'd0;
                        e_hd       = 1'b1;
                    end
`else
                    m_map[idx] = 3'd0;
                    e_hd       = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic compare();
        int         exp_rem;
        logic [2:0] exp_blk;
        exp_rem = m_loading ? count_live(m_pos) : count_live(300);
        exp_blk = (sel_row < 5'd30 && sel_col < 5'd10) ? m_map[int'(sel_row) * 10 + int'(sel_col)] : 3'd0;
        check("busy", 32'(busy), 32'(m_loading));
        check("hit_ack", 32'(hit_ack), 32'(e_ack));
        check("hit_block", 32'(hit_block), 32'(e_hb));
        check("hit_destroyed", 32'(hit_destroyed), 32'(e_hd));
        check("remaining", 32'(remaining), 32'(exp_rem));
        check("level_clear", 32'(level_clear), 32'(m_loaded && exp_rem == 0 && !m_loading));
        check("block", 32'(block), 32'(exp_blk));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic load(input logic [2:0] lv);
        int n;
        @(negedge clk);
        load_req = 1'b1;
        level    = lv;
        @(negedge clk);
        load_req = 1'b0;
        wait_idle(n);
        check("busy_cycles", 32'(n), 32'd300);
    endtask

    task automatic do_hit(input logic [4:0] r, input logic [4:0] c);
        @(negedge clk);
        hit_req = 1'b1;
        hit_row = r;
        hit_col = c;
        @(negedge clk);
        hit_req = 1'b0;
    endtask

    task automatic sweep(input int nr, input int nc);
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < nc; c++) begin
                @(negedge clk);
                sel_row = 5'(r);
                sel_col = 5'(c);
            end
        end
    endtask

    task automatic peek(input logic [4:0] r, input logic [4:0] c, input logic [2:0] exp, input string name);
        @(negedge clk);
        sel_row = r;
        sel_col = c;
        #1;
        check(name, 32'(block), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acks;
        int n;
        reset    = 1'b1;
        load_req = 1'b0;
        level    = 3'd0;
        hit_req  = 1'b0;
        hit_row  = 5'd0;
        hit_col  = 5'd0;
        sel_row  = 5'd0;
        sel_col  = 5'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("lit_reset_remaining", 32'(remaining), 32'd0);
        check("lit_reset_clear", 32'(level_clear), 32'd0);
        check("lit_reset_busy", 32'(busy), 32'd0);
        sweep(32, 16);

        // Level 0: rows 2..9 striped 100/101/110
        load(3'd0);
        check("lit_l0_remaining", 32'(remaining), 32'd80);
        check("lit_l0_clear", 32'(level_clear), 32'd0);
        peek(5'd2, 5'd3, 3'b100, "lit_l0_2_3");
        peek(5'd9, 5'd0, 3'b101, "lit_l0_9_0");
        peek(5'd4, 5'd5, 3'b110, "lit_l0_4_5");
        peek(5'd10, 5'd0, 3'b000, "lit_l0_10_0");
        sweep(30, 10);

        do_hit(5'd2, 5'd3);
        check("lit_hit1_ack", 32'(hit_ack), 32'd1);
        check("lit_hit1_block", 32'(hit_block), 32'd4);
        check("lit_hit1_destroyed", 32'(hit_destroyed), 32'd1);
        check("lit_hit1_remaining", 32'(remaining), 32'd79);
        peek(5'd2, 5'd3, 3'b000, "lit_hit1_cell");
        check("lit_ack_drop", 32'(hit_ack), 32'd0);
        do_hit(5'd2, 5'd3);
        check("lit_hit2_block", 32'(hit_block), 32'd0);
        check("lit_hit2_destroyed", 32'(hit_destroyed), 32'd0);
        check("lit_hit2_remaining", 32'(remaining), 32'd79);
        do_hit(5'd31, 5'd31);
        check("lit_oor_ack", 32'(hit_ack), 32'd1);
        check("lit_oor_block", 32'(hit_block), 32'd0);

        // Level 3: solid corners, two-hit rows 3,6,9,12
        load(3'd3);
        check("lit_l3_remaining", 32'(remaining), 32'd108);
        do_hit(5'd2, 5'd0);
        check("lit_solid_block", 32'(hit_block), 32'd7);
        check("lit_solid_destroyed", 32'(hit_destroyed), 32'd0);
        @(negedge clk);
        hit_req = 1'b1;
        hit_row = 5'd3;
        hit_col = 5'd0;
        @(negedge clk);
        check("lit_th1_block", 32'(hit_block), 32'd3);
`ifdef BLOCK_MAP_TWO_HIT_EN
        check("lit_th1_destroyed", 32'(hit_destroyed), 32'd0);
`else
        check("lit_th1_destroyed", 32'(hit_destroyed), 32'd1);
`endif
        @(negedge clk);
        hit_req = 1'b0;
`ifdef BLOCK_MAP_TWO_HIT_EN
        check("lit_th2_block", 32'(hit_block), 32'd2);
        check("lit_th2_destroyed", 32'(hit_destroyed), 32'd1);
`else
        check("lit_th2_block", 32'(hit_block), 32'd0);
        check("lit_th2_destroyed", 32'(hit_destroyed), 32'd0);
`endif
        check("lit_th_remaining", 32'(remaining), 32'd107);
        sweep(30, 10);

        // Level 1 with hits colliding with load_req and arriving while busy
        acks = 0;
        @(negedge clk);
        load_req = 1'b1;
        level    = 3'd1;
        hit_req  = 1'b1;
        hit_row  = 5'd2;
        hit_col  = 5'd2;
        @(negedge clk);
        load_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (hit_ack === 1'b1) acks++;
            hit_col = 5'(i);
            @(negedge clk);
        end
        hit_req = 1'b0;
        wait_idle(n);
        if (hit_ack === 1'b1) acks++;
        check("lit_busy_acks", 32'(acks), 32'd0);
        check("lit_l1_remaining", 32'(remaining), 32'd90);
        sweep(30, 10);

        // Level 0 cleared by 80 back-to-back hits
        load(3'd0);
        for (int r = 2; r <= 9; r++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                hit_req = 1'b1;
                hit_row = 5'(r);
                hit_col = 5'(c);
            end
        end
        @(negedge clk);
        hit_req = 1'b0;
        @(negedge clk);
        check("lit_clear_remaining", 32'(remaining), 32'd0);
        check("lit_clear_flag", 32'(level_clear), 32'd1);

        // Reset in the middle of a reload
        @(negedge clk);
        load_req = 1'b1;
        level    = 3'd7;
        @(negedge clk);
        load_req = 1'b0;
        repeat (120) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("lit_rst_busy", 32'(busy), 32'd0);
        check("lit_rst_remaining", 32'(remaining), 32'd0);
        check("lit_rst_clear", 32'(level_clear), 32'd0);
        check("lit_rst_ack", 32'(hit_ack), 32'd0);
        peek(5'd2, 5'd3, 3'b000, "lit_rst_cell");
        sweep(30, 10);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
